// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder/subtractor: FSM states and
// BCD digit constants.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit step: binary add with carry, decimal correction and
// out-of-range detection on either operand digit.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               invalid
);

    localparam int BIN_W = DIGIT_W + 1;

    logic [BIN_W-1:0] bin;
    logic [BIN_W-1:0] corr;

    always_comb begin
        bin     = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        corr    = bin + BIN_W'(BCD_CORR);
        cout    = bin > BIN_W'(BCD_MAX);
        sum     = cout ? corr[DIGIT_W-1:0] : bin[DIGIT_W-1:0];
        invalid = (a > DIGIT_W'(BCD_MAX)) || (b > DIGIT_W'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD add/subtract: operands are captured on start, processed
// one digit per cycle LSD first, and the result is published on done.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sub,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      cin,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                      cout,
    output logic                      err,
    output logic                      busy,
    output logic                      done
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    state_t         state, state_nxt;
    logic [W-1:0]   a_sh, b_sh, r_sh, r_nxt;
    logic           sub_q, carry, err_acc;
    logic [CW-1:0]  idx;
    logic           last;

    logic [DIGIT_W-1:0] b_dig, d_sum;
    logic               d_cout, d_inv;

    // A digit of 10..15 complements to 15..10, so the adder's range check
    // still flags a bad B digit in subtract mode.
    assign b_dig = sub_q ? (DIGIT_W'(BCD_MAX) - b_sh[DIGIT_W-1:0]) : b_sh[DIGIT_W-1:0];
    assign last  = (idx == CW'(DIGITS - 1));
    assign r_nxt = (r_sh >> DIGIT_W) | (W'(d_sum) << (W - DIGIT_W));

    bcd_digit_adder u_digit (
        .a       (a_sh[DIGIT_W-1:0]),
        .b       (b_dig),
        .cin     (carry),
        .sum     (d_sum),
        .cout    (d_cout),
        .invalid (d_inv)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            sub_q   <= 1'b0;
            carry   <= 1'b0;
            err_acc <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    r_sh    <= '0;
                    sub_q   <= sub;
                    carry   <= sub ? ~cin : cin;
                    err_acc <= 1'b0;
                    idx     <= '0;
                    err     <= 1'b0;
                end
                RUN: begin
                    a_sh    <= a_sh >> DIGIT_W;
                    b_sh    <= b_sh >> DIGIT_W;
                    r_sh    <= r_nxt;
                    carry   <= d_cout;
                    err_acc <= err_acc | d_inv;
                    idx     <= idx + CW'(1);
                    if (last) begin
                        if (err_acc || d_inv) begin
                            sum  <= '0;
                            cout <= 1'b0;
                            err  <= 1'b1;
                        end else begin
                            sum  <= r_nxt;
                            // Final digit carry means "no borrow" in subtract mode.
                            cout <= sub_q ? ~d_cout : d_cout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial: directed corner cases plus
// randomized operations against a decimal-arithmetic reference model.
module tb_bcd_addsub_serial;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n, start, sub, cin;
    logic [W-1:0] a, b, sum;
    logic         cout, err, busy, done;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    always #5 clk = ~clk;

    bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad_digit(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic ms, input logic mc,
                         output logic [W-1:0] es, output logic ec, output logic ee);
        longint m = 1;
        longint t;
        for (int i = 0; i < DIGITS; i++) m = m * 10;
        if (has_bad_digit(ma) || has_bad_digit(mb)) begin
            es = '0; ec = 1'b0; ee = 1'b1;
        end else if (!ms) begin
            t  = bcd2int(ma) + bcd2int(mb) + longint'(mc);
            ec = (t >= m);
            es = int2bcd(t % m);
            ee = 1'b0;
        end else begin
            t  = bcd2int(ma) - bcd2int(mb) - longint'(mc);
            ec = (t < 0);
            if (t < 0) t = t + m;
            es = int2bcd(t);
            ee = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Runs one operation; with disturb set, start is re-pulsed and the inputs
    // are scrambled while the operation is in flight.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic ts, input logic tc, input string tag,
                          input bit disturb);
        logic [W-1:0] es;
        logic         ec, ee;
        int           edges;
        bit           got;
        model(ta, tb_v, ts, tc, es, ec, ee);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        check({tag, "_busy_run"}, 64'(busy), 64'd1);
        check({tag, "_err_clr"}, 64'(err), 64'd0);
        check({tag, "_sum_hold"}, 64'(sum), 64'(prev_sum));
        got = 1'b0;
        while (!got && edges < 3 * DIGITS + 4) begin
            if (done) got = 1'b1;
            else begin
                if (disturb && edges == 2) begin
                    start = 1'b1; a = rand_bcd(); b = rand_bcd(); sub = ~ts; cin = ~tc;
                end
                if (disturb && edges == 3) start = 1'b0;
                @(negedge clk);
                edges++;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(edges), 64'(DIGITS + 1));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_err"}, 64'(err), 64'(ee));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        prev_sum  = es;
        prev_cout = ec;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_sum_keep"}, 64'(sum), 64'(es));
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        prev_sum = '0; prev_cout = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, "add_1234_5678", 1'b0);
        check("dir_6912", 64'(sum), 64'h6912);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, "add_9999_0001", 1'b0);
        check("dir_wrap_cout", 64'(cout), 64'd1);
        run_op(16'h9999, 16'h0000, 1'b0, 1'b1, "add_9999_cin", 1'b0);
        run_op(16'h5000, 16'h1234, 1'b1, 1'b0, "sub_5000_1234", 1'b0);
        check("dir_3766", 64'(sum), 64'h3766);
        run_op(16'h1234, 16'h5000, 1'b1, 1'b0, "sub_1234_5000", 1'b0);
        check("dir_6234", 64'(sum), 64'h6234);
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, "bad_digit_a", 1'b0);
        run_op(16'h0042, 16'h00F0, 1'b1, 1'b0, "bad_digit_b_sub", 1'b0);
        run_op(16'h0042, 16'h0058, 1'b0, 1'b0, "err_cleared", 1'b0);
        run_op(16'h4321, 16'h1111, 1'b0, 1'b1, "disturb_add", 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1, "sub_zero_borrow", 1'b0);

        // Reset during the second RUN cycle abandons the operation.
        @(negedge clk);
        a = 16'h2468; b = 16'h1357; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < DIGITS + 3; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        prev_sum = '0; prev_cout = 1'b0;
        run_op(16'h2468, 16'h1357, 1'b0, 1'b0, "after_reset", 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra, rb;
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand", ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
